// File: rtl/gf_pkg.sv
// gf_pkg: shared GF(2^8)/GF(2^16) constants, pipeline token type and scalar multiply.
package gf_pkg;
    localparam logic [7:0] GF_POLY = 8'h1B;
    localparam logic [7:0] SDITH_IRRED_CST_GF2P16 = 8'h20;
    localparam int GF16_W = 16;

    typedef struct packed {
        logic vld;
        logic mode;
    } tok_t;

    // Shift-and-add multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, t;
        r = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            r = b[i] ? r ^ t : r;
            t = {t[6:0], 1'b0} ^ (t[7] ? GF_POLY : 8'h00);
        end
        return r;
    endfunction
endpackage

// File: rtl/gf16_mul_lane.sv
// gf16_mul_lane: one pipelined GF(2^16) = GF(2^8)[z]/(z^2+z+0x20) product lane.
// GF16_MUL_KARATSUBA_EN selects 3 sub-multiplies instead of 4; latency is unchanged.
module gf16_mul_lane
    import gf_pkg::*;
#(
    parameter int REG_IN  = 1,
    parameter int REG_OUT = 1
) (
    input  logic              clk,
    input  logic [GF16_W-1:0] x,
    input  logic [GF16_W-1:0] y,
    output logic [GF16_W-1:0] p
);
    logic [GF16_W-1:0] xs, ys, comb;
    logic [7:0] p00, p11, mid, p00_r, p11_r, mid_r;

    generate
        if (REG_IN != 0) begin : g_in
            always_ff @(posedge clk) begin
                xs <= x;
                ys <= y;
            end
        end else begin : g_no_in
            assign xs = x;
            assign ys = y;
        end
    endgenerate

    gf_mul u_m00 (.a(xs[7:0]),  .b(ys[7:0]),  .p(p00));
    gf_mul u_m11 (.a(xs[15:8]), .b(ys[15:8]), .p(p11));

`ifdef GF16_MUL_KARATSUBA_EN
    logic [7:0] pk;
    // (x0^x1)(y0^y1) ^ x0y0 ^ x1y1 leaves the cross terms x0y1 ^ x1y0.
    gf_mul u_mk (.a(xs[7:0] ^ xs[15:8]), .b(ys[7:0] ^ ys[15:8]), .p(pk));
    assign mid = pk ^ p00 ^ p11;
`else
    logic [7:0] p01, p10;
    gf_mul u_m01 (.a(xs[7:0]),  .b(ys[15:8]), .p(p01));
    gf_mul u_m10 (.a(xs[15:8]), .b(ys[7:0]),  .p(p10));
    assign mid = p01 ^ p10;
`endif

    always_ff @(posedge clk) begin
        p00_r <= p00;
        p11_r <= p11;
        mid_r <= mid;
    end

    // z^2 = z + 0x20 folds x1y1 into both halves.
    assign comb = {mid_r ^ p11_r, p00_r ^ gf8_mul(p11_r, SDITH_IRRED_CST_GF2P16)};

    generate
        if (REG_OUT != 0) begin : g_out
            always_ff @(posedge clk) p <= comb;
        end else begin : g_no_out
            assign p = comb;
        end
    endgenerate
endmodule

// File: rtl/gf_mul.sv
// gf_mul: combinational GF(2^8) multiplier, polynomial 0x11B.
module gf_mul
    import gf_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);
    assign p = gf8_mul(a, b);
endmodule

// File: rtl/gf16_mul_acc.sv
// gf16_mul_acc: multi-lane GF(2^16) multiply/multiply-accumulate with term counter.
// Optional GF16_MUL_KARATSUBA_EN selects the 3-multiply lane datapath.
module gf16_mul_acc
    import gf_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int REG_IN  = 1,
    parameter int REG_OUT = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_mode,
    input  logic                     i_acc_clr,
    input  logic [GF16_W*LANES-1:0]  i_x,
    input  logic [GF16_W*LANES-1:0]  i_y,
    output logic [GF16_W*LANES-1:0]  o_o,
    output logic                     o_done,
    output logic [15:0]              o_count
);
    localparam int D = 1 + REG_IN + REG_OUT;

    tok_t pipe [D];
    logic [GF16_W*LANES-1:0] prod, acc_nxt;
    logic [15:0] cnt_nxt;
    logic arrive, acc_mode;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        gf16_mul_lane #(.REG_IN(REG_IN), .REG_OUT(REG_OUT)) u_lane (
            .clk(i_clk),
            .x  (i_x[GF16_W*k +: GF16_W]),
            .y  (i_y[GF16_W*k +: GF16_W]),
            .p  (prod[GF16_W*k +: GF16_W])
        );
    end

    // Valid/mode token travels in step with the lane data registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < D; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{vld: i_start, mode: i_mode};
            for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_comb begin
        arrive   = pipe[D-1].vld;
        acc_mode = pipe[D-1].mode && !i_acc_clr;
        acc_nxt  = arrive ? (acc_mode ? o_o ^ prod : prod) : (i_acc_clr ? '0 : o_o);
        cnt_nxt  = arrive ? (acc_mode ? ((&o_count) ? o_count : o_count + 16'd1) : 16'd1)
                          : (i_acc_clr ? 16'd0 : o_count);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_o     <= '0;
            o_count <= '0;
            o_done  <= 1'b0;
        end else begin
            o_o     <= acc_nxt;
            o_count <= cnt_nxt;
            o_done  <= arrive;
        end
    end
endmodule

// File: doc/gf16_mul_acc.md
GF16_MUL_ACC -- requirements
Module: gf16_mul_acc

Interface
REQ-001 SHALL have parameter LANES, default 4: number of independent GF(2^16) lanes.
REQ-002 SHALL have parameter REG_IN, default 1: 1 adds an input register stage, 0 means none.
REQ-003 SHALL have parameter REG_OUT, default 1: 1 adds a register after the lane combine stage, 0 means none.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_start, input, 1 bit: operands valid this cycle; may be asserted every cycle.
REQ-007 SHALL have port i_mode, input, 1 bit: 0 = multiply, 1 = multiply-accumulate; sampled with i_start.
REQ-008 SHALL have port i_acc_clr, input, 1 bit: clears all lane accumulators and the term counter.
REQ-009 SHALL have ports i_x and i_y, input, 16*LANES bits each: lane k operand occupies bits [16k+15:16k].
REQ-010 SHALL have port o_o, output, 16*LANES bits: per-lane accumulator contents.
REQ-011 SHALL have port o_done, output, 1 bit: one-cycle pulse marking o_o updated.
REQ-012 SHALL have port o_count, output, 16 bits: number of terms in the accumulators; saturates at 0xFFFF.

Function
REQ-013 SHALL split each lane operand as x = x1*z + x0 (x1 = [15:8], x0 = [7:0]) over GF(2^8) with polynomial 0x11B, where z^2 = z + 0x20.
REQ-014 SHALL compute per lane a0 = x0y0 ^ 0x20*(x1y1) and a1 = x0y1 ^ x1y0 ^ x1y1, with the product = {a1,a0}.
REQ-015 SHALL assert o_done exactly L = 2 + REG_IN + REG_OUT cycles after the i_start cycle (L = 4 with default parameters).
REQ-016 SHALL sustain back-to-back i_start at one result per cycle, with no stalls and in-order results.
REQ-017 SHALL carry i_mode through the pipeline alongside the data of the same i_start.
REQ-018 SHALL update the accumulator on result arrival: mode 0 gives acc = product; mode 1 gives acc = acc ^ product.
REQ-019 SHALL update o_count on result arrival: mode 0 sets it to 1; mode 1 increments it, saturating at 0xFFFF.
REQ-020 SHALL give i_acc_clr priority when it coincides with result arrival: acc = product and o_count = 1, for either mode.
REQ-021 SHALL, when i_acc_clr is asserted with no result arriving, zero acc and o_count in the next cycle, leave o_done low, and not disturb in-flight data.
REQ-022 SHALL hold o_o and o_count stable between updates.
REQ-023 SHALL drive lanes identically and independently, with no cross-lane carry.

Reset
REQ-024 SHALL, while i_rst is high, drive o_o = 0, o_count = 0 and o_done = 0, and clear every pipeline valid bit.
REQ-025 SHALL discard operations in flight when i_rst is asserted mid-operation, producing no o_done for them after reset releases.
REQ-026 SHALL ignore any i_start asserted in the same cycle as i_rst.

Configuration
REQ-027 SHALL, when macro GF16_MUL_KARATSUBA_EN is defined, use 3 GF(2^8) multiplies per lane: x0y0, x1y1 and (x0^x1)(y0^y1), with the middle term recovered by XOR.
REQ-028 SHALL, when GF16_MUL_KARATSUBA_EN is undefined, use 4 GF(2^8) multiplies per lane.
REQ-029 SHALL give identical outputs and identical latency L with or without GF16_MUL_KARATSUBA_EN.

Structure
REQ-030 SHALL place the GF(2^8) polynomial constant 8'h1B, SDITH_IRRED_CST_GF2P16 = 8'h20 and lane width 16 in shared package gf_pkg.
REQ-031 SHALL instantiate one sub-module gf16_mul_lane per lane (the combinational/pipelined product), built on the existing gf_mul.
REQ-032 SHALL keep the accumulator, o_count, valid/mode pipeline and o_done logic in the gf16_mul_acc top level.

Verification
REQ-033 SHALL verify: lane0 x = 0x0100, y = 0x0100, mode 0 -> o_done at cycle L, lane0 o_o = 0x0120.
REQ-034 SHALL verify: x = 0x0003, y = 0x0005, mode 0 -> 0x000F; then x = 0x0100, y = 0x0100, mode 1 on the next cycle -> 0x012F, o_count = 2.
REQ-035 SHALL verify: 1000 random back-to-back starts, all lanes, with both macro settings -> matches the reference model every cycle, o_done on every cycle from L onward.
REQ-036 SHALL verify: i_acc_clr coinciding with a mode-1 result of 0x000F -> acc = 0x000F, o_count = 1.
REQ-037 SHALL verify: i_rst pulsed 2 cycles after i_start -> no o_done afterwards, o_o = 0, o_count = 0.
REQ-038 SHALL verify: 65537 mode-1 starts -> o_count holds at 0xFFFF.
